rv_decode: RTL and testbench

RV_DECODE -- requirements
Module: rv_decode

---
 rtl/rv_decode.sv | 145 ++++++++++++++
 tb/tb_rv_decode.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rv_decode.sv
`default_nettype none
// ============================================================================
//  Module   : rv_decode (with package rv_pkg)
//  Purpose  : RISC-V decode stage. Holds the 32 x 32-bit integer register
//             file (x0 hard-wired to zero), generates the immediate for the
//             instruction in Q101, and registers PC, immediate and both
//             source operands into Q102. Write-back data from Q104 is
//             bypassed combinationally into the source reads.
//  Ports    : clk                 - clock, rising-edge active
//             rst                 - synchronous active-high reset
//             ctrl                - decode control (sources, imm type, ready)
//             pc_Q101H            - PC of the instruction in decode
//             instruction_Q101H   - raw instruction in decode
//             wb_data_Q104H       - write-back data
//             reg_dst_Q104H       - write-back destination register
//             reg_write_en_Q104H  - write-back enable
//             pc_Q102H            - registered PC
//             imm_Q102H           - registered immediate
//             reg_data1_Q102H     - registered rs1 value
//             reg_data2_Q102H     - registered rs2 value
//  Revision : 1.0 - initial release
// ============================================================================

package rv_pkg;

   typedef enum logic [2:0] {
      IMM_I_TYPE = 3'd0,
      IMM_S_TYPE = 3'd1,
      IMM_B_TYPE = 3'd2,
      IMM_U_TYPE = 3'd3,
      IMM_J_TYPE = 3'd4
   } t_imm_type;

   typedef struct packed {
      logic       ready_Q101H;
      logic       ready_Q102H;
      logic [4:0] reg_src1_Q101H;
      logic [4:0] reg_src2_Q101H;
      t_imm_type  sel_imm_type_Q101H;
   } t_decode_ctrl;

endpackage

module rv_decode
   import rv_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  t_decode_ctrl ctrl,
   input  logic [31:0]  pc_Q101H,
   input  logic [31:0]  instruction_Q101H,
   input  logic [31:0]  wb_data_Q104H,
   input  logic [4:0]   reg_dst_Q104H,
   input  logic         reg_write_en_Q104H,
   output logic [31:0]  pc_Q102H,
   output logic [31:0]  imm_Q102H,
   output logic [31:0]  reg_data1_Q102H,
   output logic [31:0]  reg_data2_Q102H
);

   logic [31:0] rf_q [32];
   logic        wr_valid;
   logic [31:0] imm_d;
   logic [31:0] rd1_d;
   logic [31:0] rd2_d;
   logic [31:0] pc_q;
   logic [31:0] imm_q;
   logic [31:0] rd1_q;
   logic [31:0] rd2_q;

   // Upstream handshake is owned by the fetch side; this stage ignores it.
   logic        unused_ready_q101;
   assign unused_ready_q101 = ctrl.ready_Q101H;

   // A write to x0 is never a real write, so it neither updates the file
   // nor triggers the bypass.
   assign wr_valid = reg_write_en_Q104H && (reg_dst_Q104H != 5'd0);

   // Register file: entry 0 is cleared on reset and never written.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            rf_q[i] <= 32'd0;
         end
      end else if (wr_valid) begin
         rf_q[reg_dst_Q104H] <= wb_data_Q104H;
      end
   end

   // Source reads with write-back bypass so a same-edge write reaches Q102.
   always_comb begin
      rd1_d = 32'd0;
      rd2_d = 32'd0;
      if (wr_valid && (reg_dst_Q104H == ctrl.reg_src1_Q101H)) begin
         rd1_d = wb_data_Q104H;
      end else if (ctrl.reg_src1_Q101H != 5'd0) begin
         rd1_d = rf_q[ctrl.reg_src1_Q101H];
      end
      if (wr_valid && (reg_dst_Q104H == ctrl.reg_src2_Q101H)) begin
         rd2_d = wb_data_Q104H;
      end else if (ctrl.reg_src2_Q101H != 5'd0) begin
         rd2_d = rf_q[ctrl.reg_src2_Q101H];
      end
   end

   // Immediate generation.
   always_comb begin
      imm_d = 32'd0;
      case (ctrl.sel_imm_type_Q101H)
         IMM_I_TYPE: imm_d = {{20{instruction_Q101H[31]}}, instruction_Q101H[31:20]};
         IMM_S_TYPE: imm_d = {{20{instruction_Q101H[31]}}, instruction_Q101H[31:25],
                              instruction_Q101H[11:7]};
         IMM_B_TYPE: imm_d = {{19{instruction_Q101H[31]}}, instruction_Q101H[31],
                              instruction_Q101H[7], instruction_Q101H[30:25],
                              instruction_Q101H[11:8], 1'b0};
         IMM_U_TYPE: imm_d = {instruction_Q101H[31:12], 12'd0};
         IMM_J_TYPE: imm_d = {{11{instruction_Q101H[31]}}, instruction_Q101H[31],
                              instruction_Q101H[19:12], instruction_Q101H[20],
                              instruction_Q101H[30:21], 1'b0};
         default:    imm_d = 32'd0;
      endcase
   end

   // Q101 -> Q102 pipeline registers; stall holds the current contents.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q  <= 32'd0;
         imm_q <= 32'd0;
         rd1_q <= 32'd0;
         rd2_q <= 32'd0;
      end else if (ctrl.ready_Q102H) begin
         pc_q  <= pc_Q101H;
         imm_q <= imm_d;
         rd1_q <= rd1_d;
         rd2_q <= rd2_d;
      end
   end

   assign pc_Q102H        = pc_q;
   assign imm_Q102H       = imm_q;
   assign reg_data1_Q102H = rd1_q;
   assign reg_data2_Q102H = rd2_q;

endmodule
`default_nettype wire

// File: tb/tb_rv_decode.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rv_decode
//  Purpose  : Self-checking bench for rv_decode: immediate table plus
//             hand-written register-file, bypass, stall and reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rv_decode;
   import rv_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   t_decode_ctrl ctrl;
   logic [31:0]  pc_Q101H;
   logic [31:0]  instruction_Q101H;
   logic [31:0]  wb_data_Q104H;
   logic [4:0]   reg_dst_Q104H;
   logic         reg_write_en_Q104H;
   logic [31:0]  pc_Q102H;
   logic [31:0]  imm_Q102H;
   logic [31:0]  reg_data1_Q102H;
   logic [31:0]  reg_data2_Q102H;

   int errors = 0;
   int checks = 0;

   rv_decode dut (
      .clk                (clk),
      .rst                (rst),
      .ctrl               (ctrl),
      .pc_Q101H           (pc_Q101H),
      .instruction_Q101H  (instruction_Q101H),
      .wb_data_Q104H      (wb_data_Q104H),
      .reg_dst_Q104H      (reg_dst_Q104H),
      .reg_write_en_Q104H (reg_write_en_Q104H),
      .pc_Q102H           (pc_Q102H),
      .imm_Q102H          (imm_Q102H),
      .reg_data1_Q102H    (reg_data1_Q102H),
      .reg_data2_Q102H    (reg_data2_Q102H)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] inst;
      logic [2:0]  typ;
      logic [31:0] pc;
      logic [31:0] exp_imm;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // One rising edge, then settle away from it before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_wb(input logic en, input logic [4:0] dst, input logic [31:0] data);
      reg_write_en_Q104H = en;
      reg_dst_Q104H      = dst;
      wb_data_Q104H      = data;
   endtask

   task automatic set_src(input logic [4:0] s1, input logic [4:0] s2);
      ctrl.reg_src1_Q101H = s1;
      ctrl.reg_src2_Q101H = s2;
   endtask

   initial begin
      vecs[0]  = '{"imm_I_neg", 32'hFF000293, 3'd0, 32'h0000_1000, 32'hFFFF_FFF0};
      vecs[1]  = '{"imm_I_pos", 32'h00500093, 3'd0, 32'h0000_1004, 32'h0000_0005};
      vecs[2]  = '{"imm_S_neg", 32'hFE512E23, 3'd1, 32'h0000_1008, 32'hFFFF_FFFC};
      vecs[3]  = '{"imm_S_pos", 32'h00512423, 3'd1, 32'h0000_100C, 32'h0000_0008};
      vecs[4]  = '{"imm_B_neg", 32'hFE000CE3, 3'd2, 32'h0000_1010, 32'hFFFF_FFF8};
      vecs[5]  = '{"imm_B_pos", 32'h00000863, 3'd2, 32'h0000_1014, 32'h0000_0010};
      vecs[6]  = '{"imm_U_neg", 32'hFFFFF0B7, 3'd3, 32'h0000_1018, 32'hFFFF_F000};
      vecs[7]  = '{"imm_U_pos", 32'h12345037, 3'd3, 32'h0000_101C, 32'h1234_5000};
      vecs[8]  = '{"imm_J_neg", 32'hFFDFF06F, 3'd4, 32'h0000_1020, 32'hFFFF_FFFC};
      vecs[9]  = '{"imm_J_pos", 32'h0010006F, 3'd4, 32'h0000_1024, 32'h0000_0800};
      vecs[10] = '{"imm_unused5", 32'hFFFFFFFF, 3'd5, 32'h0000_1028, 32'h0000_0000};
      vecs[11] = '{"imm_unused7", 32'hFFFFFFFF, 3'd7, 32'h0000_102C, 32'h0000_0000};

      rst  = 1'b1;
      ctrl = '0;
      pc_Q101H          = 32'hDEAD_BEEF;
      instruction_Q101H = 32'hFFFF_FFFF;
      ctrl.ready_Q102H  = 1'b1;
      set_wb(1'b0, 5'd0, 32'd0);
      step();
      step();
      chk("reset_pc",   pc_Q102H,        32'd0);
      chk("reset_imm",  imm_Q102H,       32'd0);
      chk("reset_rd1",  reg_data1_Q102H, 32'd0);
      chk("reset_rd2",  reg_data2_Q102H, 32'd0);
      rst = 1'b0;

      // Immediate table; ready_Q101H toggled to show it has no effect.
      for (int i = 0; i < 12; i++) begin
         instruction_Q101H        = vecs[i].inst;
         ctrl.sel_imm_type_Q101H  = t_imm_type'(vecs[i].typ);
         ctrl.ready_Q101H         = i[0];
         pc_Q101H                 = vecs[i].pc;
         step();
         chk(vecs[i].name, imm_Q102H, vecs[i].exp_imm);
         chk({vecs[i].name, "_pc"}, pc_Q102H, vecs[i].pc);
      end

      // Register writes then plain reads.
      set_src(5'd0, 5'd0);
      set_wb(1'b1, 5'd1, 32'hAAAA_BBBB);
      step();
      set_wb(1'b1, 5'd2, 32'hCCCC_DDDD);
      step();
      set_wb(1'b0, 5'd0, 32'd0);
      set_src(5'd1, 5'd2);
      step();
      chk("rf_read_x1", reg_data1_Q102H, 32'hAAAA_BBBB);
      chk("rf_read_x2", reg_data2_Q102H, 32'hCCCC_DDDD);

      // Same-edge write and capture of x3 goes through the bypass.
      set_src(5'd3, 5'd2);
      set_wb(1'b1, 5'd3, 32'h1234_5678);
      step();
      chk("bypass_src1", reg_data1_Q102H, 32'h1234_5678);
      chk("bypass_src2_other", reg_data2_Q102H, 32'hCCCC_DDDD);
      set_wb(1'b0, 5'd0, 32'd0);
      set_src(5'd2, 5'd3);
      step();
      chk("rf_x3_stored", reg_data2_Q102H, 32'h1234_5678);

      // Both sources bypassed at once; disabled write must not bypass.
      set_src(5'd4, 5'd4);
      set_wb(1'b1, 5'd4, 32'h0F0F_F0F0);
      step();
      chk("bypass_both_1", reg_data1_Q102H, 32'h0F0F_F0F0);
      chk("bypass_both_2", reg_data2_Q102H, 32'h0F0F_F0F0);
      set_src(5'd1, 5'd4);
      set_wb(1'b0, 5'd1, 32'h5555_5555);
      step();
      chk("no_bypass_when_disabled", reg_data1_Q102H, 32'hAAAA_BBBB);
      chk("rf_x4_stored", reg_data2_Q102H, 32'h0F0F_F0F0);

      // x0 is immune to writes, bypass included.
      set_src(5'd0, 5'd0);
      set_wb(1'b1, 5'd0, 32'hFFFF_FFFF);
      step();
      chk("x0_write_bypass", reg_data1_Q102H, 32'd0);
      set_wb(1'b0, 5'd0, 32'd0);
      step();
      chk("x0_later_read", reg_data1_Q102H, 32'd0);
      chk("x0_later_read2", reg_data2_Q102H, 32'd0);

      // Stall: Q102 holds while inputs change.
      set_src(5'd1, 5'd2);
      instruction_Q101H       = 32'h12345037;
      ctrl.sel_imm_type_Q101H = IMM_U_TYPE;
      pc_Q101H                = 32'h0000_2000;
      step();
      ctrl.ready_Q102H        = 1'b0;
      set_src(5'd3, 5'd4);
      instruction_Q101H       = 32'hFF000293;
      ctrl.sel_imm_type_Q101H = IMM_I_TYPE;
      pc_Q101H                = 32'h0000_3000;
      step();
      step();
      chk("hold_pc",  pc_Q102H,        32'h0000_2000);
      chk("hold_imm", imm_Q102H,       32'h1234_5000);
      chk("hold_rd1", reg_data1_Q102H, 32'hAAAA_BBBB);
      chk("hold_rd2", reg_data2_Q102H, 32'hCCCC_DDDD);

      // Reset beats ready and write enable; file is cleared, write dropped.
      ctrl.ready_Q102H = 1'b1;
      set_wb(1'b1, 5'd5, 32'h9999_9999);
      rst = 1'b1;
      step();
      chk("rst_pc",  pc_Q102H,        32'd0);
      chk("rst_imm", imm_Q102H,       32'd0);
      chk("rst_rd1", reg_data1_Q102H, 32'd0);
      chk("rst_rd2", reg_data2_Q102H, 32'd0);
      rst = 1'b0;
      set_wb(1'b0, 5'd0, 32'd0);
      set_src(5'd1, 5'd5);
      step();
      chk("rst_cleared_x1", reg_data1_Q102H, 32'd0);
      chk("rst_write_suppressed_x5", reg_data2_Q102H, 32'd0);
      set_src(5'd3, 5'd4);
      step();
      chk("rst_cleared_x3", reg_data1_Q102H, 32'd0);
      chk("rst_cleared_x4", reg_data2_Q102H, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, expected finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
